// File: rtl/struct_rr_merge.sv
// Round-robin merge of N_CH packed {a, b} record streams into one show-ahead FIFO.
// Each FIFO entry remembers its source channel so the consumer can demultiplex.
module struct_rr_merge #(
    parameter int N_CH  = 4,
    parameter int A_W   = 4,
    parameter int B_W   = 2,
    parameter int DEPTH = 4,
    localparam int W  = A_W + B_W,
    localparam int CW = $clog2(N_CH),
    localparam int NW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    input  logic [N_CH*W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [CW-1:0]       out_chan,
    output logic [NW-1:0]       count
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } rec_t;

    rec_t [N_CH-1:0] in_rec;
    rec_t            mem_data [DEPTH];
    logic [CW-1:0]   mem_chan [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] rr, grant;
    logic          found, full, push, pop;
    int            idx;

    assign in_rec    = in_data;
    assign full      = (count == NW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = |in_ready;
    assign out_data  = out_valid ? W'(mem_data[rd_ptr]) : '0;
    assign out_chan  = out_valid ? mem_chan[rd_ptr] : '0;

    // Scan from the farthest offset down so the channel closest to rr wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(rr) + k) % N_CH;
            if (in_valid[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    // rst_n gating keeps in_ready low while the block is held in reset.
    always_comb begin
        in_ready = '0;
        if (found && !full && !flush && rst_n)
            in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_rec[grant];
            mem_chan[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_struct_rr_merge.sv
// Scoreboard bench for struct_rr_merge: a reference arbiter/FIFO model predicts
// in_ready and queues expected {chan, record} entries that are checked at the head.
module tb_struct_rr_merge;
    localparam int N_CH = 4, A_W = 4, B_W = 2, DEPTH = 4;
    localparam int W = 6, CW = 2, NW = 3;

    logic              clk = 1'b0;
    logic              rst_n, flush, out_valid, out_ready;
    logic [N_CH-1:0]   in_valid, in_ready;
    logic [N_CH*W-1:0] in_data;
    logic [W-1:0]      out_data;
    logic [CW-1:0]     out_chan;
    logic [NW-1:0]     count;

    struct_rr_merge #(.N_CH(N_CH), .A_W(A_W), .B_W(B_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .count(count)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0;
    int         rr_m = 0, cnt_m = 0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [N_CH-1:0] v, input int rr);
        for (int k = 0; k < N_CH; k++)
            if (v[(rr + k) % N_CH]) return (rr + k) % N_CH;
        return -1;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [N_CH-1:0] exp_rdy;
        logic [7:0]      head;
        logic            push, pop;
        int              g;
        #1;
        g = model_grant(in_valid, rr_m);
        exp_rdy = '0;
        if (g >= 0 && cnt_m != DEPTH && !flush) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("count", 32'(count), 32'(cnt_m));
        chk("out_valid", 32'(out_valid), 32'(cnt_m != 0));
        head = (q.size() != 0) ? q[0] : 8'h00;
        chk("out_data", 32'(out_data), 32'(head[5:0]));
        chk("out_chan", 32'(out_chan), 32'(head[7:6]));
        push = (exp_rdy != '0);
        pop  = (cnt_m != 0) && out_ready;
        if (flush) begin
            q.delete();
            cnt_m = 0;
            rr_m  = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({2'(g), in_data[g*W +: W]});
                rr_m = (g + 1) % N_CH;
            end
            cnt_m = cnt_m + int'(push) - int'(pop);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        in_valid = 4'hF;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single record from channel 2 into an empty FIFO.
        in_valid = 4'b0100;
        in_data[2*W +: W] = 6'b1010_01;
        out_ready = 1'b1;
        #1 chk("t1_in_ready", 32'(in_ready), 32'b0100);
        cycle();
        in_valid = '0;
        #1;
        chk("t1_out_data", 32'(out_data), 32'b101001);
        chk("t1_out_chan", 32'(out_chan), 32'd2);
        cycle();
        cycle();
        chk("t1_count_drained", 32'(count), 32'd0);

        // Flush an empty FIFO to bring rr back to 0, then all channels compete.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            in_data = 24'($urandom);
            #1 chk("rr_grant", 32'(in_ready), 32'(4'b0001 << (i % 4)));
            cycle();
        end
        in_valid = '0;
        cycle();
        cycle();

        // Fill with channels 0 and 1 while the consumer stalls.
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            in_data = 24'($urandom);
            cycle();
        end
        chk("fill_count", 32'(count), 32'd4);

        // Full FIFO with a simultaneous pop: no pass-through this cycle.
        in_valid = 4'b0001;
        out_ready = 1'b1;
        #1 chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        cycle();
        chk("full_pop_count", 32'(count), 32'd3);
        #1 chk("after_full_in_ready", 32'(in_ready), 32'b0001);
        cycle();

        // Flush at count 3 blocks the push and discards the pop.
        flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        cycle();
        flush = 1'b0;
        in_valid = 4'b0110;
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);
        chk("flush_rr_grant", 32'(in_ready), 32'b0010);
        out_ready = 1'b0;
        cycle();
        in_valid = 4'b1000;
        cycle();

        // Asynchronous reset between edges with two records stored.
        in_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        cnt_m = 0;
        rr_m  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b1100;
        #1 chk("arst_first_grant", 32'(in_ready), 32'b0100);
        cycle();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 24'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        chk("final_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
